program_loader: RTL

- Write-side companion to the read-only instruction memory.
- Receives a program image as a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Drives each word into the instruction memory write port at consecutive word addresses.
- Holds the processor core in reset until the image is fully loaded, then releases it.

---
 rtl/program_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words, writes them
// to instruction memory at consecutive addresses and releases the core once loaded.
module program_loader #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         byte_valid_i,
    input  logic [7:0]                   byte_data_i,
    output logic                         byte_ready_o,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    output logic                         core_rst_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [$clog2(MEM_WORDS):0]   words_loaded_o
);

    localparam int CW = $clog2(MEM_WORDS) + 1;

    typedef enum logic [2:0] {
        S_LEN,
        S_EVAL,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     byte_cnt_q;
    logic [31:0]    len_q;
    logic [23:0]    word_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  idx_q;
    logic           ready_c;
    logic           accept;
    logic           last_byte;
    logic           last_word;

    assign accept    = byte_valid_i && byte_ready_o;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    assign last_word = ({{(32-CW){1'b0}}, idx_q} + 32'd1) == len_q;

    // NOTE: every output is decoded with a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        mem_we_o = 1'b0;
        case (state_q)
            S_LEN: begin
                ready_c = 1'b1;
                if (last_byte) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (len_q == 32'd0)                 state_d = S_DONE;
                else if (len_q > 32'(MEM_WORDS))    state_d = S_ERROR;
                else                                state_d = S_DATA;
            end
            S_DATA: begin
                ready_c = 1'b1;
                if (last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we_o = 1'b1;
                state_d  = last_word ? S_DONE : S_DATA;
            end
            S_DONE:  ;
            S_ERROR: ready_c = 1'b1;
            default: state_d = S_LEN;
        endcase
    end

    // Ready is held low while reset is asserted even though S_LEN itself is a ready state.
    assign byte_ready_o   = ready_c && rst_ni;
    assign mem_addr_o     = BASE_ADDR + {{(30-CW){1'b0}}, idx_q, 2'b00};
    assign mem_wdata_o    = wdata_q;
    assign core_rst_o     = (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign error_o        = (state_q == S_ERROR);
    assign words_loaded_o = idx_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_LEN;
            byte_cnt_q <= 2'd0;
            len_q      <= 32'd0;
            word_q     <= 24'd0;
            wdata_q    <= 32'd0;
            idx_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept && (state_q == S_LEN || state_q == S_DATA))
                byte_cnt_q <= byte_cnt_q + 2'd1;
            if (accept && state_q == S_LEN)
                len_q <= {byte_data_i, len_q[31:8]};
            if (accept && state_q == S_DATA) begin
                word_q <= {byte_data_i, word_q[23:8]};
                if (byte_cnt_q == 2'd3) wdata_q <= {byte_data_i, word_q};
            end
            if (state_q == S_WRITE)
                idx_q <= idx_q + 1'b1;
        end
    end

endmodule
